fp16_recip_dispatch: RTL and testbench

FP16_RECIP_DISPATCH -- requirements
Module: fp16_recip_dispatch

---
 rtl/fp16_recip_dispatch.sv | 156 +++++++++++++++
 tb/tb_fp16_recip_dispatch.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_recip_dispatch.sv
// fp16_recip_dispatch: single-entry dispatcher between an FP16 denominator
// stream and an external multi-cycle reciprocal unit. Zero denominators are
// answered directly with a signed infinity. All other values are issued to
// the unit, and its result is forwarded. If the unit never answers, a qNaN is
// returned and the sticky err flag is raised.
//
// Optional feature: define RECIP_WARMSTART_EN to request a warm start
// (recip_from_last) whenever the previous completed operand has the same
// exponent as the new one.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    denominator handshake, in_data = FP16 x
//   recip_start          one-cycle start pulse to the reciprocal unit
//   recip_x              operand, held stable until the unit answers
//   recip_from_last      warm-start select, recip_last = previous result
//   recip_result/done    unit result and one-cycle completion pulse
//   out_valid/out_ready  result handshake, out_data = FP16 1/x
//   err                  sticky timeout flag, cleared only by reset
module fp16_recip_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        recip_start,
  output logic [15:0] recip_x,
  output logic        recip_from_last,
  output logic [15:0] recip_last,
  input  logic [15:0] recip_result,
  input  logic        recip_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [15:0] QNaN = 16'h7E00;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [15:0]     x_reg;
  logic [15:0]     last_recip;
  logic            warm_hit;
  logic            x_is_zero;

  // The unit reads its operand combinationally while it computes, so the
  // captured operand register drives it directly.
  assign recip_x    = x_reg;
  assign recip_last = last_recip;
  assign x_is_zero  = (in_data[14:0] == 15'd0);

`ifdef RECIP_WARMSTART_EN
  logic [15:0] last_x;
  logic        last_ok;

  // Same exponent as the previous good result: its reciprocal is a close seed.
  assign warm_hit = last_ok && (in_data[14:10] == last_x[14:10]);
`else
  assign warm_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= StIdle;
      in_ready        <= 1'b0;
      recip_start     <= 1'b0;
      recip_from_last <= 1'b0;
      x_reg           <= 16'h0000;
      last_recip      <= 16'h0000;
      out_valid       <= 1'b0;
      out_data        <= 16'h0000;
      err             <= 1'b0;
      cnt             <= '0;
`ifdef RECIP_WARMSTART_EN
      last_x          <= 16'h0000;
      last_ok         <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            x_reg    <= in_data;
            in_ready <= 1'b0;
            if (x_is_zero) begin
              // 1/(+-0) = +-inf; the unit is never involved.
              out_data  <= {in_data[15], 15'h7C00};
              out_valid <= 1'b1;
              state     <= StOut;
`ifdef RECIP_WARMSTART_EN
              last_ok   <= 1'b0;
`endif
            end else begin
              // Start and warm-start select are registered so they are
              // visible exactly during the ISSUE cycle.
              recip_start     <= 1'b1;
              recip_from_last <= warm_hit;
              state           <= StIssue;
            end
          end
        end

        StIssue: begin
          recip_start     <= 1'b0;
          recip_from_last <= 1'b0;
          cnt             <= '0;
          state           <= StWait;
        end

        StWait: begin
          // A completion in the timeout cycle still counts as a completion.
          if (recip_done) begin
            out_data   <= recip_result;
            out_valid  <= 1'b1;
            last_recip <= recip_result;
            state      <= StOut;
`ifdef RECIP_WARMSTART_EN
            last_x     <= x_reg;
            last_ok    <= 1'b1;
`endif
          end else if (cnt == CntW'(TIMEOUT_CYCLES)) begin
            out_data  <= QNaN;
            out_valid <= 1'b1;
            err       <= 1'b1;
            state     <= StOut;
`ifdef RECIP_WARMSTART_EN
            last_ok   <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StOut: begin
          // in_ready rises only on entering IDLE, so no input is taken in
          // the same cycle as the output handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_recip_dispatch.sv
// Testbench for fp16_recip_dispatch. A behavioural reciprocal unit answers
// recip_start after a programmable latency. A transaction-level reference
// model predicts the output value, err, the warm-start request and the latency.
module tb_fp16_recip_dispatch;

  localparam int unsigned TO = 15;

`ifdef RECIP_WARMSTART_EN
  localparam bit WarmEn = 1'b1;
`else
  localparam bit WarmEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        recip_start;
  logic [15:0] recip_x;
  logic        recip_from_last;
  logic [15:0] recip_last;
  logic [15:0] recip_result;
  logic        recip_done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        err;

  always #5 clk = ~clk;

  fp16_recip_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .recip_start     (recip_start),
    .recip_x         (recip_x),
    .recip_from_last (recip_from_last),
    .recip_last      (recip_last),
    .recip_result    (recip_result),
    .recip_done      (recip_done),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .err             (err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit          last_ok_m    = 1'b0;
  logic [15:0] last_x_m     = 16'h0000;
  logic [15:0] last_recip_m = 16'h0000;
  bit          err_m        = 1'b0;

  // Behavioural reciprocal unit.
  bit          unit_en  = 1'b1;
  int          unit_lat = 2;
  int          pend     = 0;
  int          starts   = 0;
  logic [15:0] seen_x;
  logic [15:0] seen_last;
  logic        seen_from_last;

  // Stand-in reciprocal: exact for powers of two (1/2^k = 2^-k).
  function automatic logic [15:0] unit_recip(input logic [15:0] x);
    logic [4:0] e;
    e = 5'd30 - x[14:10];
    return {x[15], e, (x[9:0] == 10'd0) ? 10'd0 : ~x[9:0]};
  endfunction

  initial begin
    recip_done   = 1'b0;
    recip_result = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      recip_done = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) recip_done = 1'b1;
      end
      if (recip_start === 1'b1) begin
        starts         = starts + 1;
        seen_x         = recip_x;
        seen_last      = recip_last;
        seen_from_last = recip_from_last;
        recip_result   = unit_recip(recip_x);
        if (unit_en) pend = unit_lat;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [15:0] x, input int lat, input bit respond,
                         input int hold, input string tag);
    bit          zero;
    bit          exp_fl;
    logic [15:0] exp_data;
    int          n;
    int          s0;
    int          lat_obs;
    zero     = (x[14:0] == 15'd0);
    exp_fl   = WarmEn && last_ok_m && (x[14:10] == last_x_m[14:10]);
    exp_data = zero ? {x[15], 15'h7C00} : (respond ? unit_recip(x) : 16'h7E00);
    unit_en  = respond;
    unit_lat = lat;

    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready: got %b want 1 within 50 cycles", tag, in_ready);
      return;
    end
    s0       = starts;
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);

    n = 0;
    while (out_valid !== 1'b1 && n < int'(TO) + 20) begin
      tick();
      n++;
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s out_valid: got %b want 1 within bound", tag, out_valid);
      return;
    end
    lat_obs = n + 1;  // counted from the accept cycle

    n_vec++;
    if (zero ? (lat_obs != 1) : respond ? (lat_obs != lat + 2)
             : (lat_obs < int'(TO) + 2 || lat_obs > int'(TO) + 3)) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat_obs,
               zero ? 1 : respond ? lat + 2 : int'(TO) + 3);
    end

    n_vec++;
    if (out_data !== exp_data) begin
      n_err++;
      $display("FAIL %s out_data: got %h want %h", tag, out_data, exp_data);
    end

    if (!zero && !respond) err_m = 1'b1;
    n_vec++;
    if (err !== err_m) begin
      n_err++;
      $display("FAIL %s err: got %b want %b", tag, err, err_m);
    end

    if (!zero) begin
      n_vec++;
      if (seen_x !== x || seen_from_last !== exp_fl || seen_last !== last_recip_m) begin
        n_err++;
        $display("FAIL %s issue: got x=%h fl=%b last=%h want x=%h fl=%b last=%h", tag,
                 seen_x, seen_from_last, seen_last, x, exp_fl, last_recip_m);
      end
    end

    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp_data || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold[%0d]: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0", tag, i,
                 out_valid, out_data, in_ready, exp_data);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", tag, out_valid, in_ready);
    end

    n_vec++;
    if (starts - s0 != (zero ? 0 : 1)) begin
      n_err++;
      $display("FAIL %s starts: got %0d want %0d", tag, starts - s0, zero ? 0 : 1);
    end

    if (zero || !respond) begin
      last_ok_m = 1'b0;
    end else begin
      last_ok_m    = 1'b1;
      last_x_m     = x;
      last_recip_m = exp_data;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if (in_ready !== 1'b0 || recip_start !== 1'b0 || recip_x !== 16'h0 ||
        recip_from_last !== 1'b0 || recip_last !== 16'h0 || out_valid !== 1'b0 ||
        out_data !== 16'h0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL %s reset outputs: got rdy=%b st=%b x=%h fl=%b last=%h v=%b d=%h err=%b want all 0",
               tag, in_ready, recip_start, recip_x, recip_from_last, recip_last, out_valid,
               out_data, err);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_txn(16'h4000, 2, 1'b1, 0, "basic");
    n_vec++;
    if (last_recip_m !== 16'h3800) begin
      n_err++;
      $display("FAIL basic recip_last: got %h want 3800", recip_last);
    end
  endtask

  task automatic test_bypass();
    run_txn(16'h0000, 2, 1'b1, 0, "bypass_pos");
    run_txn(16'h8000, 2, 1'b1, 1, "bypass_neg");
  endtask

  task automatic test_warmstart();
    run_txn(16'h4000, 1, 1'b1, 0, "warm_first");
    run_txn(16'h4200, 3, 1'b1, 0, "warm_second");
    n_vec++;
    if (seen_from_last !== WarmEn || seen_last !== 16'h3800) begin
      n_err++;
      $display("FAIL warm_second seed: got fl=%b last=%h want fl=%b last=3800",
               seen_from_last, seen_last, WarmEn);
    end
  endtask

  task automatic test_timeout();
    run_txn(16'h4100, 2, 1'b0, 0, "timeout");
    run_txn(16'h4100, 2, 1'b1, 0, "after_timeout");
    n_vec++;
    if (seen_from_last !== 1'b0) begin
      n_err++;
      $display("FAIL after_timeout warm: got %b want 0", seen_from_last);
    end
  endtask

  task automatic test_backpressure();
    run_txn(16'h3C00, 2, 1'b1, 10, "backpressure");
  endtask

  task automatic test_random();
    logic [15:0] x;
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom);
      if ($urandom_range(0, 5) == 0) x[14:0] = 15'd0;
      else if ($urandom_range(0, 2) == 0) x[14:10] = last_x_m[14:10];
      if (x[14:0] == 15'd0 && $urandom_range(0, 1) == 0) x[10] = 1'b1;
      run_txn(x, int'($urandom_range(1, 5)), $urandom_range(0, 9) != 0,
              int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_reset_mid_wait();
    int s0;
    unit_en  = 1'b1;
    unit_lat = 8;
    s0       = starts;
    in_valid = 1'b1;
    in_data  = 16'h4400;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_wait");
    repeat (2) tick();
    rst_n        = 1'b1;
    last_ok_m    = 1'b0;
    last_recip_m = 16'h0000;
    err_m        = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || recip_start !== 1'b0) begin
        n_err++;
        $display("FAIL mid_wait idle[%0d]: got v=%b st=%b want v=0 st=0", i, out_valid,
                 recip_start);
      end
    end
    n_vec++;
    if (in_ready !== 1'b1 || starts - s0 != 1 || pend != 0) begin
      n_err++;
      $display("FAIL mid_wait end: got rdy=%b starts=%0d pend=%0d want rdy=1 starts=1 pend=0",
               in_ready, starts - s0, pend);
    end
    run_txn(16'h4000, 2, 1'b1, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_warmstart();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
